// File: rtl/sram_bus_slave_pkg.sv
// Shared definitions for the 16-bit system bus SRAM responder.
package sram_bus_slave_pkg;

  localparam int unsigned BUS_DATA_WIDTH = 16;
  localparam int unsigned WAIT_CNT_WIDTH = 4;

  // 25 MHz clock (40 ns) with a 55 ns SRAM: three strobe cycles (120 ns)
  // cover the access time plus address setup and pad delays.
  localparam int unsigned DEFAULT_WAIT_STATES = 2;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    ACK
  } state_t;

endpackage

// File: rtl/sram_bus_slave.sv
// Single-word bus responder driving a timed access on an asynchronous 16-bit SRAM.
module sram_bus_slave
  import sram_bus_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [15:0]               i_addr,
  input  logic [BUS_DATA_WIDTH-1:0] i_dat,
  output logic [BUS_DATA_WIDTH-1:0] o_dat,
  input  logic                      i_cs,
  input  logic                      i_we,
  output logic                      o_ack,
  output logic [ADDR_WIDTH-1:0]     o_sram_addr,
  output logic [BUS_DATA_WIDTH-1:0] o_sram_dat,
  input  logic [BUS_DATA_WIDTH-1:0] i_sram_dat,
  output logic                      o_sram_dat_oe,
  output logic                      o_sram_ce_n,
  output logic                      o_sram_oe_n,
  output logic                      o_sram_we_n
);

  state_t                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      wr_q, wr_d;

  logic                      ack_d;
  logic [BUS_DATA_WIDTH-1:0] dat_d;
  logic [ADDR_WIDTH-1:0]     sram_addr_d;
  logic [BUS_DATA_WIDTH-1:0] sram_dat_d;
  logic                      sram_dat_oe_d;
  logic                      sram_ce_n_d;
  logic                      sram_oe_n_d;
  logic                      sram_we_n_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    ack_d         = o_ack;
    dat_d         = o_dat;
    sram_addr_d   = o_sram_addr;
    sram_dat_d    = o_sram_dat;
    sram_dat_oe_d = o_sram_dat_oe;
    sram_ce_n_d   = o_sram_ce_n;
    sram_oe_n_d   = o_sram_oe_n;
    sram_we_n_d   = o_sram_we_n;

    unique case (state_q)
      IDLE: begin
        if (i_cs) begin
          wr_d        = i_we;
          sram_addr_d = i_addr[ADDR_WIDTH-1:0];
          sram_ce_n_d = 1'b0;
          if (i_we) begin
            sram_we_n_d   = 1'b0;
            sram_dat_oe_d = 1'b1;
            sram_dat_d    = i_dat;
          end else begin
            sram_oe_n_d = 1'b0;
          end
          cnt_d   = WAIT_CNT_WIDTH'(WAIT_STATES);
          state_d = STROBE;
        end
      end

      STROBE: begin
        if (cnt_q == '0) begin
          // Writes release we_n one cycle early so data and address are held past its rising edge.
          if (wr_q) begin
            sram_we_n_d = 1'b1;
          end else begin
            dat_d = i_sram_dat;
          end
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ACK: begin
        ack_d         = 1'b0;
        sram_ce_n_d   = 1'b1;
        sram_oe_n_d   = 1'b1;
        sram_we_n_d   = 1'b1;
        sram_dat_oe_d = 1'b0;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      o_ack         <= 1'b0;
      o_dat         <= '0;
      o_sram_addr   <= '0;
      o_sram_dat    <= '0;
      o_sram_dat_oe <= 1'b0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      o_ack         <= ack_d;
      o_dat         <= dat_d;
      o_sram_addr   <= sram_addr_d;
      o_sram_dat    <= sram_dat_d;
      o_sram_dat_oe <= sram_dat_oe_d;
      o_sram_ce_n   <= sram_ce_n_d;
      o_sram_oe_n   <= sram_oe_n_d;
      o_sram_we_n   <= sram_we_n_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_slave.sv
// Scoreboard bench: stimulus queues expected accesses, one monitor checks pins, acks and data.
module tb_sram_bus_slave;
  import sram_bus_slave_pkg::*;

  typedef struct {
    int          start;
    int          ack_k;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] dat;
    logic [15:0] odat;
  } txn_t;

  localparam int ACK0 = 4;  // WAIT_STATES=2
  localparam int ACK1 = 2;  // WAIT_STATES=0

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic done  = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] addr0, dat0, odat0, saddr0, swdat0, srdat0;
  logic        cs0, we0, ack0, soe0, ce_n0, oe_n0, we_n0;
  logic [15:0] addr1, dat1, odat1, saddr1, swdat1, srdat1;
  logic        cs1, we1, ack1, soe1, ce_n1, oe_n1, we_n1;

  sram_bus_slave #(.ADDR_WIDTH(16), .WAIT_STATES(2)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr0), .i_dat(dat0), .o_dat(odat0),
    .i_cs(cs0), .i_we(we0), .o_ack(ack0), .o_sram_addr(saddr0), .o_sram_dat(swdat0),
    .i_sram_dat(srdat0), .o_sram_dat_oe(soe0), .o_sram_ce_n(ce_n0),
    .o_sram_oe_n(oe_n0), .o_sram_we_n(we_n0)
  );

  sram_bus_slave #(.ADDR_WIDTH(16), .WAIT_STATES(0)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr1), .i_dat(dat1), .o_dat(odat1),
    .i_cs(cs1), .i_we(we1), .o_ack(ack1), .o_sram_addr(saddr1), .o_sram_dat(swdat1),
    .i_sram_dat(srdat1), .o_sram_dat_oe(soe1), .o_sram_ce_n(ce_n1),
    .o_sram_oe_n(oe_n1), .o_sram_we_n(we_n1)
  );

  // SRAM models: combinational read, write latched on the rising edge of we_n
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  logic        pre_stb0 = 1'b0, pre_stb1 = 1'b0;
  logic [15:0] pre_addr0, pre_dat0, pre_addr1, pre_dat1;

  assign srdat0 = (!ce_n0 && !oe_n0) ? mem0[saddr0] : 16'hDEAD;
  assign srdat1 = (!ce_n1 && !oe_n1) ? mem1[saddr1] : 16'hDEAD;

  always @(posedge we_n0 or posedge pre_stb0) begin
    if (pre_stb0) mem0[pre_addr0] <= pre_dat0;
    else if (!ce_n0) mem0[saddr0] <= swdat0;
  end

  always @(posedge we_n1 or posedge pre_stb1) begin
    if (pre_stb1) mem1[pre_addr1] <= pre_dat1;
    else if (!ce_n1) mem1[saddr1] <= swdat1;
  end

  txn_t q0[$];
  txn_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag, input logic ack, input logic [15:0] odat,
                             input logic ce_n, oe_n, we_n, soe, input logic [15:0] saddr, swdat);
    chk({tag, " rst ack"}, 32'(ack), 32'd0);
    chk({tag, " rst o_dat"}, 32'(odat), 32'd0);
    chk({tag, " rst ce_n"}, 32'(ce_n), 32'd1);
    chk({tag, " rst oe_n"}, 32'(oe_n), 32'd1);
    chk({tag, " rst we_n"}, 32'(we_n), 32'd1);
    chk({tag, " rst dat_oe"}, 32'(soe), 32'd0);
    chk({tag, " rst sram_addr"}, 32'(saddr), 32'd0);
    chk({tag, " rst sram_dat"}, 32'(swdat), 32'd0);
  endtask

  task automatic check_dut(input string tag, input bit have, input txn_t h,
                           input logic ack, ce_n, oe_n, we_n, soe,
                           input logic [15:0] saddr, swdat, odat, memw, output bit pop);
    int k;
    pop = 1'b0;
    k = have ? cyc - h.start : -1;
    if (!have || k <= 0) begin
      chk({tag, " idle ack"}, 32'(ack), 32'd0);
      chk({tag, " idle ce_n"}, 32'(ce_n), 32'd1);
      chk({tag, " idle oe_n"}, 32'(oe_n), 32'd1);
      chk({tag, " idle we_n"}, 32'(we_n), 32'd1);
      chk({tag, " idle dat_oe"}, 32'(soe), 32'd0);
    end else if (k < h.ack_k) begin
      chk({tag, " strobe ack"}, 32'(ack), 32'd0);
      chk({tag, " strobe ce_n"}, 32'(ce_n), 32'd0);
      chk({tag, " strobe sram_addr"}, 32'(saddr), 32'(h.addr));
      if (h.wr) begin
        chk({tag, " wr we_n"}, 32'(we_n), 32'd0);
        chk({tag, " wr oe_n"}, 32'(oe_n), 32'd1);
        chk({tag, " wr dat_oe"}, 32'(soe), 32'd1);
        chk({tag, " wr sram_dat"}, 32'(swdat), 32'(h.dat));
      end else begin
        chk({tag, " rd oe_n"}, 32'(oe_n), 32'd0);
        chk({tag, " rd we_n"}, 32'(we_n), 32'd1);
        chk({tag, " rd dat_oe"}, 32'(soe), 32'd0);
      end
    end else begin
      chk({tag, " ack"}, 32'(ack), 32'd1);
      chk({tag, " ack ce_n"}, 32'(ce_n), 32'd0);
      chk({tag, " ack sram_addr"}, 32'(saddr), 32'(h.addr));
      chk({tag, " ack we_n"}, 32'(we_n), 32'd1);
      if (h.wr) begin
        chk({tag, " hold dat_oe"}, 32'(soe), 32'd1);
        chk({tag, " sram content"}, 32'(memw), 32'(h.dat));
        chk({tag, " o_dat kept"}, 32'(odat), 32'(h.odat));
      end else begin
        chk({tag, " rd dat_oe"}, 32'(soe), 32'd0);
        chk({tag, " o_dat"}, 32'(odat), 32'(h.dat));
      end
      pop = 1'b1;
    end
  endtask

  always begin : monitor
    txn_t h0, h1;
    bit   pop0, pop1;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      check_reset("dut0", ack0, odat0, ce_n0, oe_n0, we_n0, soe0, saddr0, swdat0);
      check_reset("dut1", ack1, odat1, ce_n1, oe_n1, we_n1, soe1, saddr1, swdat1);
      q0.delete();
      q1.delete();
    end else begin
      h0 = '{default: 0};
      h1 = '{default: 0};
      if (q0.size() > 0) h0 = q0[0];
      if (q1.size() > 0) h1 = q1[0];
      check_dut("dut0", q0.size() > 0, h0, ack0, ce_n0, oe_n0, we_n0, soe0,
                saddr0, swdat0, odat0, mem0[h0.addr], pop0);
      check_dut("dut1", q1.size() > 0, h1, ack1, ce_n1, oe_n1, we_n1, soe1,
                saddr1, swdat1, odat1, mem1[h1.addr], pop1);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (done) begin
        chk("dut0 queue drained", 32'(q0.size()), 32'd0);
        chk("dut1 queue drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  task automatic preload0(input logic [15:0] a, d);
    pre_addr0 = a; pre_dat0 = d; pre_stb0 = 1'b1;
    #1 pre_stb0 = 1'b0;
  endtask

  task automatic preload1(input logic [15:0] a, d);
    pre_addr1 = a; pre_dat1 = d; pre_stb1 = 1'b1;
    #1 pre_stb1 = 1'b0;
  endtask

  // Called at a falling edge; lead=1 when the request is first seen one cycle later.
  task automatic issue0(input logic w, input logic [15:0] a, d, expv, od, input int lead);
    cs0 = 1'b1; we0 = w; addr0 = a; dat0 = d;
    q0.push_back('{start: cyc + lead, ack_k: ACK0, wr: w, addr: a, dat: expv, odat: od});
  endtask

  task automatic run0(input logic w, input logic [15:0] a, d, expv, od, input int drop_k);
    issue0(w, a, d, expv, od, 0);
    for (int k = 1; k <= ACK0 + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        addr0 = ~a; dat0 = ~d; we0 = ~w;
      end
      if (k == drop_k) cs0 = 1'b0;
    end
  endtask

  initial begin
    cs0 = 1'b0; we0 = 1'b0; addr0 = '0; dat0 = '0;
    cs1 = 1'b0; we1 = 1'b0; addr1 = '0; dat1 = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // read with default wait states
    preload0(16'h0123, 16'hBEEF);
    @(negedge clk);
    run0(1'b0, 16'h0123, 16'h0000, 16'hBEEF, 16'h0000, ACK0);

    // write leaves o_dat alone
    run0(1'b1, 16'h0040, 16'h55AA, 16'h55AA, 16'hBEEF, ACK0);

    // back-to-back write then read of the same word
    issue0(1'b1, 16'h0010, 16'h1234, 16'h1234, 16'hBEEF, 0);
    repeat (ACK0) @(negedge clk);
    issue0(1'b0, 16'h0010, 16'h0000, 16'h1234, 16'h0000, 1);
    repeat (ACK0 + 1) @(negedge clk);
    cs0 = 1'b0;
    repeat (3) @(negedge clk);

    // cs dropped in cycle 2 of a read
    preload0(16'h0200, 16'hC0DE);
    @(negedge clk);
    run0(1'b0, 16'h0200, 16'h0000, 16'hC0DE, 16'h0000, 2);
    repeat (3) @(negedge clk);

    // reset in cycle 2 of a write, then a normal read
    issue0(1'b1, 16'h0300, 16'hFFFF, 16'hFFFF, 16'hC0DE, 0);
    repeat (2) @(negedge clk);
    cs0 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    preload0(16'h0077, 16'hA5C3);
    @(negedge clk);
    run0(1'b0, 16'h0077, 16'h0000, 16'hA5C3, 16'h0000, ACK0);

    // zero wait-state build
    preload1(16'h0000, 16'h0F0F);
    @(negedge clk);
    cs1 = 1'b1; we1 = 1'b0; addr1 = 16'h0000;
    q1.push_back('{start: cyc, ack_k: ACK1, wr: 1'b0, addr: 16'h0000, dat: 16'h0F0F, odat: 16'h0000});
    for (int k = 1; k <= ACK1 + 3; k++) begin
      @(negedge clk);
      if (k == ACK1) cs1 = 1'b0;
    end

    repeat (2) @(negedge clk);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench did not reach its summary");
  end

endmodule

// File: doc/sram_bus_slave.md
Name: sram_bus_slave

Overview:
- Bus responder for the 16-bit system bus driven by the master shell (VGA master, UART master).
- Converts a single-word bus request (cs/we/addr/dat) into a timed access on an external asynchronous 16-bit SRAM.
- Returns the handshake on o_ack.
- The slave-select decode sits outside this block; i_cs is already qualified.

Parameters:
- ADDR_WIDTH, 16: SRAM address width; the low ADDR_WIDTH bits of i_addr are used.
- WAIT_STATES, 2: extra strobe cycles beyond the minimum of one; legal range 0..15.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_addr  in  16  bus word address
- i_dat  in  16  bus write data
- o_dat  out  16  bus read data, registered
- i_cs  in  1  bus request, held by master until o_ack
- i_we  in  1  1 = write, 0 = read; valid with i_cs
- o_ack  out  1  single-cycle completion pulse
- o_sram_addr  out  ADDR_WIDTH  SRAM address
- o_sram_dat  out  16  SRAM write data
- i_sram_dat  in  16  SRAM read data
- o_sram_dat_oe  out  1  tristate enable for the data pins (top level builds the inout)
- o_sram_ce_n  out  1  chip enable, active low
- o_sram_oe_n  out  1  output enable, active low
- o_sram_we_n  out  1  write enable, active low

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous, active-low on i_reset_n. Reset is synchronously released by the top level.
- Reset values: o_ack=0, o_dat=0, o_sram_ce_n=1, o_sram_oe_n=1, o_sram_we_n=1, o_sram_dat_oe=0, o_sram_addr=0, o_sram_dat=0, state=IDLE.
- All outputs are registered; no combinational path from bus inputs to any output.
- State IDLE:
  - Outputs are inactive.
  - On an edge with i_cs=1: latch the address, i_dat and i_we.
  - Drive o_sram_ce_n=0 and o_sram_addr.
    - Read: o_sram_oe_n=0.
    - Write: o_sram_we_n=0, o_sram_dat_oe=1, o_sram_dat=latched data.
  - Load the wait counter with WAIT_STATES; go to STROBE.
- State STROBE (WAIT_STATES+1 cycles):
  - Strobes held; counter decrements each cycle.
  - On the edge where the counter is 0:
    - Read: capture i_sram_dat into o_dat.
    - Write: raise o_sram_we_n while o_sram_dat_oe and the address stay driven (data hold).
  - Assert o_ack; go to ACK.
- State ACK (1 cycle):
  - o_ack=1 for exactly this cycle.
  - On exit: ce_n=1, oe_n=1, o_sram_dat_oe=0, o_ack=0; go to IDLE.
- Latency: cycle 0 is the first cycle i_cs=1 with state IDLE. Strobe cycles are 1..WAIT_STATES+1; o_ack is high in cycle WAIT_STATES+2. With the default, o_ack is in cycle 4.
- Read data: o_dat is valid in the ACK cycle and holds until the next read completes. Writes never alter o_dat.
- Back-to-back: the master must drop i_cs in the cycle after o_ack. If i_cs is still high in IDLE, it is treated as a new request. Minimum request spacing is WAIT_STATES+3 cycles.
- Inputs during an access: i_addr, i_dat and i_we changes are ignored until IDLE.
- i_cs dropped mid-access: the access is not aborted. The SRAM cycle completes and o_ack still pulses once; upstream gating discards it.
- Reset mid-access: all SRAM strobes go inactive immediately and o_ack=0. A write in progress may be partially written; this is accepted.
- Addressing: o_sram_addr = i_addr[ADDR_WIDTH-1:0]; upper bits are ignored.
- Counter: width is 4 bits. WAIT_STATES=0 gives a single strobe cycle.

Decomposition:
- Shared bus package holds:
  - state encoding localparams: IDLE, STROBE, ACK;
  - bus data width constant (16);
  - default WAIT_STATES for a 25 MHz system clock with a 55 ns SRAM.
- No sub-module: the FSM, wait counter and output registers stay in one module.

Test Plan:
- Read, WAIT_STATES=2: preload SRAM model addr 0x0123=0xBEEF; i_cs=1, i_we=0, i_addr=0x0123 -> oe_n low cycles 1-3, o_ack high only in cycle 4, o_dat=0xBEEF in cycle 4.
- Write: i_we=1, i_addr=0x0040, i_dat=0x55AA -> we_n low cycles 1-3, data_oe high cycles 1-4, o_ack in cycle 4, model holds 0x55AA; o_dat unchanged.
- Back-to-back: write 0x1234 to 0x0010, drop cs one cycle after o_ack, then read 0x0010 -> second o_ack 5 cycles after the first, o_dat=0x1234.
- cs dropped in cycle 2 of a read -> access completes, exactly one o_ack in cycle 4, no second access started.
- i_reset_n low in cycle 2 of a write -> same cycle: we_n=1, ce_n=1, data_oe=0, o_ack=0; after release, IDLE accepts a new read normally.
- WAIT_STATES=0 build: read 0x0000=0x0F0F -> strobe only in cycle 1, o_ack in cycle 2, o_dat=0x0F0F.
